signal_beacon_tx: RTL and testbench
===================================

# signal_beacon_tx

Signal-side beacon for the approach-warning link. Sequences the GREEN → YELLOW → RED traffic-signal phases from programmable durations and generates the one-second tick. Broadcasts the seconds remaining until the next phase change, both as a parallel `valid_data`/`data_out` strobe and as a serial frame. The parallel strobe feeds the vehicle-side countdown subtractor directly, and that subtractor reaches zero on the same tick that this block changes phase.

## Interface

Parameters:
- `CLK_PER_SEC`, default 50000000: clock cycles per second tick; must be ≥ 2.
- `CLK_PER_BIT`, default 434: clock cycles per serial bit; must be ≥ 2.
- `RESYNC_SEC`, default 5: seconds between repeat broadcasts within a phase; 0 disables repeats.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `enable`, in, 1: run/freeze.
- `green_time`, in, 6: GREEN duration in seconds.
- `yellow_time`, in, 6: YELLOW duration in seconds.
- `red_time`, in, 6: RED duration in seconds.
- `phase`, out, 2: current phase (IDLE/GREEN/YELLOW/RED).
- `remaining`, out, 6: seconds left in the current phase, range N..1.
- `seconds_tick`, out, 1: one-cycle pulse each second.
- `valid_data`, out, 1: one-cycle broadcast strobe.
- `data_out`, out, 6: broadcast value, equal to `remaining` when `valid_data` is high.
- `tx_serial`, out, 1: serial line; idle high.
- `tx_busy`, out, 1: high while a frame is being shifted.

## Operation

- Reset values: `phase`=IDLE, `remaining`=0, `data_out`=0, `valid_data`=0, `seconds_tick`=0, `tx_serial`=1, `tx_busy`=0. Divider, resync counter and pending buffer are cleared.
- Divider:
  - Counts 0..CLK_PER_SEC-1 while `enable`=1 and `phase`≠IDLE.
  - `seconds_tick` is a registered pulse, high for the cycle after the count hits CLK_PER_SEC-1.
  - Holds while `enable`=0.
- Phase FSM, states IDLE, GREEN, YELLOW, RED:
  - IDLE with `enable`=1 → GREEN, `remaining`=`green_time`, divider=0.
  - On `seconds_tick` with `remaining`>1: `remaining` decrements.
  - On `seconds_tick` with `remaining`≤1: advance GREEN→YELLOW→RED→GREEN and load the new phase's time.
  - Durations are sampled only at phase entry. A duration of 0 is loaded as 1.
- Broadcast events:
  - Any phase entry.
  - A tick with no phase change on which the seconds-in-phase counter reaches RESYNC_SEC. That counter clears on phase entry and after each resync broadcast.
- On a broadcast event, `valid_data` pulses for one cycle with `data_out` = the new `remaining`. A serial frame carrying {`phase`,`remaining`} (8 bits) is posted at the same time.
- Serial frame format: start bit 0, then 8 data bits LSB first (`remaining[0]` first, `phase[1]` last), then stop bit 1. Each bit lasts CLK_PER_BIT cycles.
- Serial buffering:
  - There is a 1-deep pending buffer.
  - A frame posted while `tx_busy`=1 overwrites the pending buffer, so only the latest value is kept.
  - The pending frame starts the cycle after the current stop bit ends.
- `enable`=0: phase, `remaining`, divider and resync counter freeze, and no broadcasts occur. A frame already in flight completes, and the pending frame is still sent.
- Reset mid-frame: `tx_serial` goes high on the reset edge; the in-flight and pending frames are discarded.

## Timing

- The phase/`remaining` update, `valid_data` and `data_out` are all registered on the edge that samples `seconds_tick`=1. They are therefore visible the cycle after the tick pulse, and `valid_data` never coincides with `seconds_tick`.
- Entry from IDLE: `phase`, `remaining` and `valid_data` are valid the cycle after `enable` is first sampled high. The first tick follows CLK_PER_SEC cycles later.
- Serial start: the start bit is driven the cycle after posting if the line is idle. `tx_busy` rises with the start bit and falls the cycle after the stop bit completes. A frame is 10×CLK_PER_BIT cycles.
- A phase of N seconds spans exactly N ticks. The receiver loads N and reaches 0 on the tick that causes the phase change.

## Structure

- Shared package `signal_pkg`:
  - Phase encodings IDLE=2'd0, GREEN=2'd1, YELLOW=2'd2, RED=2'd3.
  - `FRAME_BITS`=8.
  - `TIME_W`=6.
- Sub-module `uart_tx_byte`: bit-rate counter, 10-bit shifter and busy flag, with a `start`/`data[7:0]` input.
- The top level holds the divider, the phase FSM, the resync counter and the pending buffer.

## Test plan

Common parameters: CLK_PER_SEC=10, CLK_PER_BIT=4, RESYNC_SEC=3.

- Basic phase entry and countdown: reset, green=4/yellow=2/red=3, `enable`=1.
  - `valid_data` fires next cycle with `data_out`=4, `phase`=GREEN.
  - `remaining` reads 4,3,2,1 on successive ticks.
  - On the 4th tick: YELLOW, `data_out`=2.
  - After 2 more ticks: RED, `data_out`=3. After 3 more ticks: GREEN, `data_out`=4.
- Resync and zero duration: green=8.
  - Broadcast at entry (8), then after 3 ticks (5), then after 6 ticks (2).
  - With yellow=0: YELLOW lasts exactly 1 tick, and its broadcast shows `data_out`=1.
- Serial frame check: entry broadcast for GREEN with 4.
  - `tx_serial` shows 0, then bits 0,0,1,0,0,0,1,0 (value 0x44), then 1, each 4 cycles wide.
  - `tx_busy` is high for 40 cycles.
- Overwrite while busy: force two broadcasts during one frame (CLK_PER_BIT=50).
  - Only the second value is sent after the first frame ends.
- Freeze: `enable`=0 for 25 cycles mid-phase.
  - No `seconds_tick`, `remaining` unchanged, in-flight frame completes.
  - On re-enable, the divider resumes from its held count.
- Reset mid-frame: assert `reset` during the data bits.
  - Next cycle `tx_serial`=1, `tx_busy`=0, `phase`=IDLE, `remaining`=0.
  - No pending frame is sent afterwards.

Source files
------------

// File: rtl/signal_pkg.sv
// Shared definitions for the approach-warning signal beacon: phase encodings,
// field widths and small helpers used by the phase sequencer.
package signal_pkg;

    localparam int FRAME_BITS = 8;
    localparam int TIME_W     = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } phase_e;

    // A zero duration would never count down, so it is treated as one second.
    function automatic logic [TIME_W-1:0] load_time(input logic [TIME_W-1:0] t);
        return (t == '0) ? TIME_W'(1) : t;
    endfunction

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            GREEN:   return YELLOW;
            YELLOW:  return RED;
            default: return GREEN;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, stop bit.
// A new frame may be accepted on the last stop-bit cycle for back-to-back output.
module uart_tx_byte
    import signal_pkg::*;
#(
    parameter int CLK_PER_BIT = 434
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] data_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int              CNT_W    = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_BIT - 1);
    localparam int              SH_W     = FRAME_BITS + 2;
    localparam logic [3:0]      LAST_IDX = 4'(SH_W - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic             busy_q, busy_d;
    logic             tx_q, tx_d;
    logic             bit_end, frame_end;

    assign bit_end   = busy_q && (cnt_q == CNT_MAX);
    assign frame_end = bit_end && (idx_q == LAST_IDX);
    assign ready_o   = !busy_q || frame_end;

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        sh_d   = sh_q;
        busy_d = busy_q;
        if (start_i && ready_o) begin
            busy_d = 1'b1;
            sh_d   = {1'b1, data_i, 1'b0};
            cnt_d  = '0;
            idx_d  = '0;
        end else if (busy_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    busy_d = 1'b0;
                end else begin
                    idx_d = idx_q + 4'd1;
                    sh_d  = {1'b1, sh_q[SH_W-1:1]};
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        tx_d = busy_d ? sh_d[0] : 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            sh_q   <= '1;
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
            busy_q <= busy_d;
            tx_q   <= tx_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/signal_beacon_tx.sv
// Signal-side beacon: sequences GREEN/YELLOW/RED from programmable durations and
// broadcasts the seconds remaining as a parallel strobe and a serial frame.
module signal_beacon_tx
    import signal_pkg::*;
#(
    parameter int CLK_PER_SEC = 50000000,
    parameter int CLK_PER_BIT = 434,
    parameter int RESYNC_SEC  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [TIME_W-1:0] green_time,
    input  logic [TIME_W-1:0] yellow_time,
    input  logic [TIME_W-1:0] red_time,
    output logic [1:0]        phase,
    output logic [TIME_W-1:0] remaining,
    output logic              seconds_tick,
    output logic              valid_data,
    output logic [TIME_W-1:0] data_out,
    output logic              tx_serial,
    output logic              tx_busy
);

    localparam int               DIV_W   = $clog2(CLK_PER_SEC);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_PER_SEC - 1);
    localparam logic [7:0]       RS_TGT  = 8'(RESYNC_SEC);
    localparam bit               RS_ON   = (RESYNC_SEC != 0);

    phase_e              phase_q, phase_d, nxt;
    logic [TIME_W-1:0]   rem_q, rem_d, entry_t;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [7:0]          sec_q, sec_d, sec_inc;
    logic                tick_q, tick_d;
    logic                vld_q, vld_d;
    logic [TIME_W-1:0]   dout_q, dout_d;

    logic                  pend_vld_q, pend_vld_d;
    logic [FRAME_BITS-1:0] pend_data_q, pend_data_d;
    logic [FRAME_BITS-1:0] post_frame, tx_data;
    logic                  tx_ready, tx_start;

    always_comb begin
        nxt = next_phase(phase_q);
        case (nxt)
            YELLOW:  entry_t = yellow_time;
            RED:     entry_t = red_time;
            default: entry_t = green_time;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        rem_d   = rem_q;
        div_d   = div_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        vld_d   = 1'b0;
        dout_d  = dout_q;
        sec_inc = sec_q + 8'd1;
        if (phase_q == IDLE) begin
            if (enable) begin
                phase_d = nxt;
                rem_d   = load_time(entry_t);
                div_d   = '0;
                sec_d   = '0;
                vld_d   = 1'b1;
                dout_d  = rem_d;
            end
        end else begin
            if (enable) begin
                if (div_q == DIV_MAX) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            // A tick is only ever raised while enabled, so it is always consumed
            // to keep the broadcast countdown in step with the receiver.
            if (tick_q) begin
                if (rem_q > TIME_W'(1)) begin
                    rem_d = rem_q - 1'b1;
                    if (RS_ON && (sec_inc == RS_TGT)) begin
                        sec_d  = '0;
                        vld_d  = 1'b1;
                        dout_d = rem_d;
                    end else begin
                        sec_d = sec_inc;
                    end
                end else begin
                    phase_d = nxt;
                    rem_d   = load_time(entry_t);
                    sec_d   = '0;
                    vld_d   = 1'b1;
                    dout_d  = rem_d;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            vld_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            phase_q <= phase_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
        end
    end

    // A broadcast posts a frame; a busy line parks it, keeping only the latest.
    assign post_frame = {phase_q, rem_q};
    assign tx_start   = tx_ready && (vld_q || pend_vld_q);
    assign tx_data    = vld_q ? post_frame : pend_data_q;

    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        if (vld_q && !tx_ready) begin
            pend_vld_d  = 1'b1;
            pend_data_d = post_frame;
        end else if (tx_start) begin
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
        end
    end

    uart_tx_byte #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_uart (
        .clock  (clock),
        .reset  (reset),
        .start_i(tx_start),
        .data_i (tx_data),
        .ready_o(tx_ready),
        .tx_o   (tx_serial),
        .busy_o (tx_busy)
    );

    assign phase        = phase_q;
    assign remaining    = rem_q;
    assign seconds_tick = tick_q;
    assign valid_data   = vld_q;
    assign data_out     = dout_q;

endmodule

// File: tb/tb_signal_beacon_tx.sv
// Directed bench for signal_beacon_tx: phase sequencing table, resync, serial
// framing, overwrite of the pending frame, freeze and reset mid-frame.
module tb_signal_beacon_tx;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, enable;
    logic [5:0] green_time, yellow_time, red_time;
    logic [1:0] phase;
    logic [5:0] remaining, data_out;
    logic       seconds_tick, valid_data, tx_serial, tx_busy;

    logic       b_reset, b_enable;
    logic [5:0] b_green, b_yellow, b_red;
    logic [1:0] b_phase;
    logic [5:0] b_remaining, b_data_out;
    logic       b_tick, b_valid, b_tx, b_busy;

    signal_beacon_tx #(.CLK_PER_SEC(10), .CLK_PER_BIT(4), .RESYNC_SEC(3)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .green_time(green_time), .yellow_time(yellow_time), .red_time(red_time),
        .phase(phase), .remaining(remaining), .seconds_tick(seconds_tick),
        .valid_data(valid_data), .data_out(data_out),
        .tx_serial(tx_serial), .tx_busy(tx_busy)
    );

    signal_beacon_tx #(.CLK_PER_SEC(10), .CLK_PER_BIT(50), .RESYNC_SEC(0)) dut_b (
        .clock(clock), .reset(b_reset), .enable(b_enable),
        .green_time(b_green), .yellow_time(b_yellow), .red_time(b_red),
        .phase(b_phase), .remaining(b_remaining), .seconds_tick(b_tick),
        .valid_data(b_valid), .data_out(b_data_out),
        .tx_serial(b_tx), .tx_busy(b_busy)
    );

    typedef struct {
        int off;
        int ph;
        int rem;
        int vld;
        int dout;
        int tck;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   cur = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cur++;
    endtask

    task automatic go_to(input int off);
        while (cur < off) step();
    endtask

    task automatic start_a(input int g, input int y, input int r);
        reset  = 1'b1;
        enable = 1'b0;
        step();
        step();
        reset       = 1'b0;
        green_time  = 6'(g);
        yellow_time = 6'(y);
        red_time    = 6'(r);
        enable      = 1'b1;
        step();
        cur = 0;
    endtask

    initial begin
        logic [7:0] frame;
        logic [7:0] frame_b;
        int         ev_off[$];
        int         ev_dat[$];
        int         bad;
        int         bi;
        int         exp_tx;
        int         exp_off[4];
        int         exp_dat[4];

        reset = 1'b1; enable = 1'b0;
        green_time = '0; yellow_time = '0; red_time = '0;
        b_reset = 1'b1; b_enable = 1'b0;
        b_green = '0; b_yellow = '0; b_red = '0;

        tbl.push_back('{0,  1, 4, 1, 4, 0});
        tbl.push_back('{1,  1, 4, 0, 0, 0});
        tbl.push_back('{9,  1, 4, 0, 0, 0});
        tbl.push_back('{10, 1, 4, 0, 0, 1});
        tbl.push_back('{11, 1, 3, 0, 0, 0});
        tbl.push_back('{21, 1, 2, 0, 0, 0});
        tbl.push_back('{30, 1, 2, 0, 0, 1});
        tbl.push_back('{31, 1, 1, 1, 1, 0});
        tbl.push_back('{41, 2, 2, 1, 2, 0});
        tbl.push_back('{51, 2, 1, 0, 0, 0});
        tbl.push_back('{61, 3, 3, 1, 3, 0});
        tbl.push_back('{71, 3, 2, 0, 0, 0});
        tbl.push_back('{81, 3, 1, 0, 0, 0});
        tbl.push_back('{91, 1, 4, 1, 4, 0});

        // Reset state
        step();
        step();
        check("rst_phase", int'(phase), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid", int'(valid_data), 0);
        check("rst_tick", int'(seconds_tick), 0);
        check("rst_tx", int'(tx_serial), 1);
        check("rst_busy", int'(tx_busy), 0);

        // Phase sequencing table
        start_a(4, 2, 3);
        for (int i = 0; i < tbl.size(); i++) begin
            go_to(tbl[i].off);
            check($sformatf("tbl%0d_phase", tbl[i].off), int'(phase), tbl[i].ph);
            check($sformatf("tbl%0d_rem", tbl[i].off), int'(remaining), tbl[i].rem);
            check($sformatf("tbl%0d_valid", tbl[i].off), int'(valid_data), tbl[i].vld);
            check($sformatf("tbl%0d_tick", tbl[i].off), int'(seconds_tick), tbl[i].tck);
            if (tbl[i].vld != 0)
                check($sformatf("tbl%0d_data", tbl[i].off), int'(data_out), tbl[i].dout);
        end

        // Serial frame for the GREEN entry broadcast with 4
        start_a(4, 2, 3);
        frame = 8'h44;
        check("ser_busy0", int'(tx_busy), 0);
        check("ser_tx0", int'(tx_serial), 1);
        for (int k = 1; k <= 40; k++) begin
            go_to(k);
            bi = (k - 1) / 4;
            exp_tx = (bi == 0) ? 0 : (bi == 9) ? 1 : int'(frame[bi-1]);
            check($sformatf("ser_tx_c%0d", k), int'(tx_serial), exp_tx);
            check($sformatf("ser_busy_c%0d", k), int'(tx_busy), 1);
        end
        go_to(41);
        check("ser_pending_start", int'(tx_serial), 0);

        // Resync broadcasts and zero-length YELLOW
        start_a(8, 0, 3);
        check("rs_entry_valid", int'(valid_data), 1);
        check("rs_entry_data", int'(data_out), 8);
        for (int k = 1; k <= 91; k++) begin
            step();
            if (valid_data) begin
                ev_off.push_back(cur);
                ev_dat.push_back(int'(data_out));
            end
            if (cur == 81) check("rs_yellow_phase", int'(phase), 2);
            if (cur == 91) check("rs_red_phase", int'(phase), 3);
        end
        exp_off = '{31, 61, 81, 91};
        exp_dat = '{5, 2, 1, 3};
        check("rs_event_count", ev_off.size(), 4);
        for (int i = 0; i < 4 && i < ev_off.size(); i++) begin
            check($sformatf("rs_ev%0d_cycle", i), ev_off[i], exp_off[i]);
            check($sformatf("rs_ev%0d_data", i), ev_dat[i], exp_dat[i]);
        end

        // Freeze mid-phase for 25 cycles
        start_a(8, 2, 3);
        go_to(15);
        check("frz_rem_before", int'(remaining), 7);
        enable = 1'b0;
        for (int k = 16; k <= 40; k++) begin
            step();
            check($sformatf("frz_tick_c%0d", k), int'(seconds_tick), 0);
            check($sformatf("frz_rem_c%0d", k), int'(remaining), 7);
            check($sformatf("frz_valid_c%0d", k), int'(valid_data), 0);
            if (k == 30) check("frz_tx_bit6", int'(tx_serial), 1);
            if (k == 34) check("frz_tx_bit7", int'(tx_serial), 0);
            if (k == 38) check("frz_tx_stop", int'(tx_serial), 1);
        end
        check("frz_busy_end", int'(tx_busy), 1);
        enable = 1'b1;
        step();
        check("frz_busy_done", int'(tx_busy), 0);
        go_to(44);
        check("frz_no_tick_early", int'(seconds_tick), 0);
        go_to(45);
        check("frz_tick_resume", int'(seconds_tick), 1);
        go_to(46);
        check("frz_rem_after", int'(remaining), 6);

        // Reset during data bits, with a resync frame already pending
        start_a(4, 2, 3);
        go_to(34);
        check("mid_tx_bit7", int'(tx_serial), 0);
        check("mid_busy", int'(tx_busy), 1);
        reset  = 1'b1;
        enable = 1'b0;
        step();
        check("mid_rst_tx", int'(tx_serial), 1);
        check("mid_rst_busy", int'(tx_busy), 0);
        check("mid_rst_phase", int'(phase), 0);
        check("mid_rst_rem", int'(remaining), 0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (!tx_serial || tx_busy) bad++;
        end
        check("mid_no_frame_after", bad, 0);

        // Two broadcasts during one long frame: only the latest is sent
        b_reset = 1'b1;
        step();
        step();
        b_reset  = 1'b0;
        b_green  = 6'd4;
        b_yellow = 6'd2;
        b_red    = 6'd50;
        b_enable = 1'b1;
        step();
        cur = 0;
        frame_b = 8'hF2;
        check("ovw_entry_data", int'(b_data_out), 4);
        go_to(1);
        check("ovw_start_bit", int'(b_tx), 0);
        go_to(41);
        check("ovw_yel_valid", int'(b_valid), 1);
        check("ovw_yel_data", int'(b_data_out), 2);
        go_to(61);
        check("ovw_red_valid", int'(b_valid), 1);
        check("ovw_red_data", int'(b_data_out), 50);
        go_to(500);
        check("ovw_f1_stop", int'(b_tx), 1);
        check("ovw_f1_busy", int'(b_busy), 1);
        go_to(501);
        check("ovw_f2_start", int'(b_tx), 0);
        check("ovw_f2_busy", int'(b_busy), 1);
        for (int k = 0; k < 8; k++) begin
            go_to(501 + 50 * (k + 1) + 25);
            check($sformatf("ovw_f2_bit%0d", k), int'(b_tx), int'(frame_b[k]));
        end
        go_to(976);
        check("ovw_f2_stop", int'(b_tx), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
